spi_receiver: RTL and testbench

SPI slave-side deserializer placed directly downstream of the transmitter. It takes the transmitter's sck, cs_n and mosi lines, oversamples them in the system clock domain, and rebuilds p_data_width-bit words. Completed words go into a small show-ahead FIFO that the consumer reads through a valid/ready handshake. It serves as the loopback checker and as the receive front end for on-chip SPI links.

---
 rtl/spi_receiver.sv | 242 ++++++++++++++++++++++++
 tb/tb_spi_receiver.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/spi_receiver.sv
// SPI slave deserializer: oversamples sck/cs_n/mosi in the clk domain, rebuilds
// words and queues them in a show-ahead FIFO drained by a valid/ready handshake.
module spi_receiver #(
    parameter int p_data_width  = 8,
    parameter int p_fifo_depth  = 4,
    parameter int p_cs_polar    = 1,
    parameter int p_sample_edge = 1,
    parameter int p_msb_first   = 1
) (
    input  logic                    clk,
    input  logic                    s_rst,
    input  logic                    sck,
    input  logic                    cs_n,
    input  logic                    mosi,
    output logic [p_data_width-1:0] data,
    output logic                    valid,
    input  logic                    ready,
    output logic                    busy,
    output logic                    overrun,
    output logic                    frame_err
);

    localparam int c_ptr_w = $clog2(p_fifo_depth);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_bit_w = (p_data_width > 2) ? $clog2(p_data_width) : 1;
    localparam logic c_cs_idle = (p_cs_polar != 0) ? 1'b1 : 1'b0;
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(p_data_width - 1);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(p_fifo_depth);

    typedef enum logic [0:0] {
        st_idle   = 1'b0,
        st_active = 1'b1
    } state_t;

    function automatic logic [p_data_width-1:0] shift_in(
        input logic [p_data_width-1:0] sh,
        input logic                    b
    );
        logic [p_data_width-1:0] res;
        if (p_msb_first != 0) begin
            res = {sh[p_data_width-2:0], b};
        end else begin
            res = {b, sh[p_data_width-1:1]};
        end
        return res;
    endfunction

    // synchronizer and edge-detect stages
    logic sck_s1_r, sck_s2_r, sck_d_r;
    logic cs_s1_r, cs_s2_r;
    logic mosi_s1_r, mosi_s2_r;
    logic samp_s;
    logic samp_r, mosi_r, cs_act_r;

    // FSM / shifter state
    state_t                  state_r;
    logic [c_bit_w-1:0]      bit_cnt_r;
    logic [c_bit_w-1:0]      cnt_after_s;
    logic [p_data_width-1:0] shift_r;
    logic [p_data_width-1:0] shift_next_s;
    logic                    word_done_s;
    logic                    push_r;
    logic [p_data_width-1:0] push_data_r;
    logic                    busy_r;
    logic                    frame_err_r;

    // FIFO state
    logic [p_data_width-1:0] mem_r [p_fifo_depth];
    logic [c_ptr_w-1:0]      wr_ptr_r, rd_ptr_r, rd_ptr_n_s;
    logic [c_cnt_w-1:0]      count_r, count_n_s;
    logic                    pop_s, full_s, push_ok_s, overrun_s;
    logic [p_data_width-1:0] head_n_s;
    logic [p_data_width-1:0] data_r;
    logic                    valid_r;
    logic                    overrun_r;

    // Two-flop synchronizers; the extra stage registers the aligned edge, data and cs
    always_ff @(posedge clk) begin
        if (s_rst) begin
            sck_s1_r  <= 1'b0;
            sck_s2_r  <= 1'b0;
            sck_d_r   <= 1'b0;
            cs_s1_r   <= c_cs_idle;
            cs_s2_r   <= c_cs_idle;
            mosi_s1_r <= 1'b0;
            mosi_s2_r <= 1'b0;
            samp_r    <= 1'b0;
            mosi_r    <= 1'b0;
            cs_act_r  <= 1'b0;
        end else begin
            sck_s1_r  <= sck;
            sck_s2_r  <= sck_s1_r;
            sck_d_r   <= sck_s2_r;
            cs_s1_r   <= cs_n;
            cs_s2_r   <= cs_s1_r;
            mosi_s1_r <= mosi;
            mosi_s2_r <= mosi_s1_r;
            samp_r    <= samp_s;
            mosi_r    <= mosi_s2_r;
            cs_act_r  <= (cs_s2_r != c_cs_idle);
        end
    end

    // Select the sampling transition of the synchronized sck
    always_comb begin
        samp_s = 1'b0;
        if (p_sample_edge != 0) begin
            samp_s = sck_s2_r & ~sck_d_r;
        end else begin
            samp_s = ~sck_s2_r & sck_d_r;
        end
    end

    // Next shifter value, word completion and bit count after this cycle's sample
    always_comb begin
        shift_next_s = shift_in(shift_r, mosi_r);
        word_done_s  = samp_r && (bit_cnt_r == c_last_bit);
        cnt_after_s  = bit_cnt_r;
        if (samp_r) begin
            if (word_done_s) begin
                cnt_after_s = {c_bit_w{1'b0}};
            end else begin
                cnt_after_s = bit_cnt_r + c_bit_w'(1);
            end
        end else begin
            cnt_after_s = bit_cnt_r;
        end
    end

    // Frame FSM: shifts bits, hands completed words to the FIFO, flags partial frames
    always_ff @(posedge clk) begin
        if (s_rst) begin
            state_r     <= st_idle;
            bit_cnt_r   <= {c_bit_w{1'b0}};
            shift_r     <= {p_data_width{1'b0}};
            push_r      <= 1'b0;
            push_data_r <= {p_data_width{1'b0}};
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
            case (state_r)
                st_idle: begin
                    if (cs_act_r) begin
                        state_r   <= st_active;
                        busy_r    <= 1'b1;
                        bit_cnt_r <= {c_bit_w{1'b0}};
                        shift_r   <= {p_data_width{1'b0}};
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                st_active: begin
                    if (samp_r) begin
                        shift_r <= shift_next_s;
                    end else begin
                        shift_r <= shift_r;
                    end
                    if (word_done_s) begin
                        push_r      <= 1'b1;
                        push_data_r <= shift_next_s;
                    end else begin
                        push_data_r <= push_data_r;
                    end
                    // a word finishing together with cs release still counts as complete
                    if (!cs_act_r) begin
                        state_r     <= st_idle;
                        busy_r      <= 1'b0;
                        bit_cnt_r   <= {c_bit_w{1'b0}};
                        frame_err_r <= (cnt_after_s != {c_bit_w{1'b0}});
                    end else begin
                        busy_r      <= 1'b1;
                        bit_cnt_r   <= cnt_after_s;
                    end
                end
                default: begin
                    state_r   <= st_idle;
                    busy_r    <= 1'b0;
                    bit_cnt_r <= {c_bit_w{1'b0}};
                end
            endcase
        end
    end

    // FIFO next-state; the head output is precomputed so data/valid come from flops
    always_comb begin
        pop_s     = valid_r & ready;
        full_s    = (count_r == c_full_cnt);
        push_ok_s = push_r & (~full_s | pop_s);
        overrun_s = push_r & full_s & ~pop_s;
        if (pop_s) begin
            rd_ptr_n_s = rd_ptr_r + c_ptr_w'(1);
        end else begin
            rd_ptr_n_s = rd_ptr_r;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_n_s = count_r + c_cnt_w'(1);
            2'b01:   count_n_s = count_r - c_cnt_w'(1);
            default: count_n_s = count_r;
        endcase
        if (push_ok_s && (wr_ptr_r == rd_ptr_n_s)) begin
            head_n_s = push_data_r;
        end else begin
            head_n_s = mem_r[rd_ptr_n_s];
        end
    end

    // FIFO storage, pointers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (s_rst) begin
            for (int i = 0; i < p_fifo_depth; i++) begin
                mem_r[i] <= {p_data_width{1'b0}};
            end
            wr_ptr_r  <= {c_ptr_w{1'b0}};
            rd_ptr_r  <= {c_ptr_w{1'b0}};
            count_r   <= {c_cnt_w{1'b0}};
            data_r    <= {p_data_width{1'b0}};
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data_r;
                wr_ptr_r        <= wr_ptr_r + c_ptr_w'(1);
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            rd_ptr_r  <= rd_ptr_n_s;
            count_r   <= count_n_s;
            valid_r   <= (count_n_s != {c_cnt_w{1'b0}});
            data_r    <= (count_n_s != {c_cnt_w{1'b0}}) ? head_n_s : {p_data_width{1'b0}};
            overrun_r <= overrun_s;
        end
    end

    assign data      = data_r;
    assign valid     = valid_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_receiver.sv
// Directed bench for spi_receiver: default instance plus an LSB-first,
// falling-edge, active-high-cs instance.
module tb_spi_receiver;

    logic       clk;
    logic       s_rst;
    logic       sck, cs_n, mosi, ready;
    logic [7:0] data;
    logic       valid, busy, overrun, frame_err;
    logic       sck2, cs2, mosi2, ready2;
    logic [7:0] data2;
    logic       valid2, busy2, overrun2, frame_err2;

    int         n_cmp;
    int         n_err;
    int         ovr_cnt;
    int         ferr_cnt;
    int         snap_ovr;
    int         snap_ferr;
    logic [7:0] pop_q [$];

    spi_receiver dut (
        .clk(clk), .s_rst(s_rst), .sck(sck), .cs_n(cs_n), .mosi(mosi),
        .data(data), .valid(valid), .ready(ready), .busy(busy),
        .overrun(overrun), .frame_err(frame_err)
    );

    spi_receiver #(
        .p_data_width(8), .p_fifo_depth(4), .p_cs_polar(0),
        .p_sample_edge(0), .p_msb_first(0)
    ) dut2 (
        .clk(clk), .s_rst(s_rst), .sck(sck2), .cs_n(cs2), .mosi(mosi2),
        .data(data2), .valid(valid2), .ready(ready2), .busy(busy2),
        .overrun(overrun2), .frame_err(frame_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record popped words and error pulses mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (valid && ready) pop_q.push_back(data);
        if (overrun) ovr_cnt = ovr_cnt + 1;
        if (frame_err) ferr_cnt = ferr_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pops(input string tag, input logic [7:0] exp_w [5], input int n);
        logic [31:0] got;
        check_eq({tag, "_count"}, pop_q.size(), n);
        for (int i = 0; i < n; i++) begin
            got = (i < pop_q.size()) ? {24'h0, pop_q[i]} : 32'hFFFF_FFFF;
            check_eq($sformatf("%s_%0d", tag, i), got, {24'h0, exp_w[i]});
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // MSB-first bits on dut: mosi set with sck low, sampled on the rise; sck left high
    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = w[7-i];
            sck  = 1'b0;
            tick(2);
            sck  = 1'b1;
            tick(2);
        end
    endtask

    logic [7:0] opt_bits [8];

    initial begin
        n_cmp = 0; n_err = 0; ovr_cnt = 0; ferr_cnt = 0;
        s_rst = 1'b1;
        sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; ready = 1'b0;
        sck2 = 1'b0; cs2 = 1'b0; mosi2 = 1'b0; ready2 = 1'b0;
        tick(3);
        check_eq("rst_flags", {valid, busy, overrun, frame_err}, 4'b0000);
        check_eq("rst_data", data, 8'h00);
        s_rst = 1'b0;
        tick(2);

        // single word 0xA5 with latency check
        snap_ovr = ovr_cnt; snap_ferr = ferr_cnt; pop_q.delete();
        ready = 1'b1; cs_n = 1'b0;
        tick(4);
        check_eq("t1_busy", busy, 1'b1);
        send_bits(8'hA5, 7);
        mosi = 1'b1; sck = 1'b0; tick(2); sck = 1'b1;
        tick(4);
        check_eq("t1_valid_early", valid, 1'b0);
        tick(1);
        check_eq("t1_valid_data", {valid, data}, {1'b1, 8'hA5});
        tick(1);
        check_eq("t1_valid_after", valid, 1'b0);
        sck = 1'b0; tick(2); cs_n = 1'b1; tick(6);
        check_eq("t1_busy_off", busy, 1'b0);
        check_eq("t1_ovr", ovr_cnt - snap_ovr, 0);
        check_eq("t1_ferr", ferr_cnt - snap_ferr, 0);
        check_pops("t1_pop", '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00}, 1);

        // fill four words, fifth overruns, then drain
        snap_ovr = ovr_cnt; pop_q.delete();
        ready = 1'b0; cs_n = 1'b0;
        tick(4);
        send_bits(8'h11, 8); send_bits(8'h22, 8); send_bits(8'h33, 8);
        send_bits(8'h44, 8); send_bits(8'h55, 8);
        sck = 1'b0; tick(8); cs_n = 1'b1; tick(6);
        check_eq("t2_ovr", ovr_cnt - snap_ovr, 1);
        check_eq("t2_head", {valid, data}, {1'b1, 8'h11});
        ready = 1'b1; tick(8); ready = 1'b0;
        check_eq("t2_valid_end", valid, 1'b0);
        check_pops("t2_pop", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00}, 4);

        // partial frame then a clean one
        snap_ferr = ferr_cnt; pop_q.delete();
        cs_n = 1'b0; tick(4);
        send_bits(8'hFF, 5);
        sck = 1'b0; tick(2); cs_n = 1'b1; tick(6);
        check_eq("t3_ferr", ferr_cnt - snap_ferr, 1);
        check_eq("t3_valid", valid, 1'b0);
        ready = 1'b1; cs_n = 1'b0; tick(4);
        send_bits(8'h3C, 8);
        sck = 1'b0; tick(8); cs_n = 1'b1; tick(6);
        check_eq("t3_ferr_clean", ferr_cnt - snap_ferr, 1);
        check_pops("t3_pop", '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00}, 1);

        // push and pop in the same cycle while full
        snap_ovr = ovr_cnt; pop_q.delete();
        ready = 1'b0; cs_n = 1'b0; tick(4);
        send_bits(8'h11, 8); send_bits(8'h22, 8); send_bits(8'h33, 8); send_bits(8'h44, 8);
        send_bits(8'h66, 7);
        mosi = 1'b0; sck = 1'b0; tick(2); sck = 1'b1;
        tick(4);
        ready = 1'b1;
        tick(1);
        check_eq("t4_head", {valid, data}, {1'b1, 8'h22});
        tick(8);
        sck = 1'b0; tick(2); cs_n = 1'b1; tick(6);
        check_eq("t4_ovr", ovr_cnt - snap_ovr, 0);
        check_pops("t4_pop", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66}, 5);

        // reset in the middle of a word
        pop_q.delete();
        ready = 1'b1; cs_n = 1'b0; tick(4);
        send_bits(8'hC3, 3);
        sck = 1'b0; tick(2);
        check_eq("t5_busy_pre", busy, 1'b1);
        snap_ferr = ferr_cnt;
        s_rst = 1'b1; tick(1);
        check_eq("t5_rst_flags", {valid, busy, overrun, frame_err}, 4'b0000);
        check_eq("t5_rst_data", data, 8'h00);
        s_rst = 1'b0; tick(4);
        send_bits(8'h81, 8);
        sck = 1'b0; tick(8); cs_n = 1'b1; tick(6);
        check_eq("t5_ferr", ferr_cnt - snap_ferr, 0);
        check_pops("t5_pop", '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00}, 1);

        // LSB-first, falling-edge sampling, active-high cs
        opt_bits = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        cs2 = 1'b1; tick(4);
        check_eq("t6_busy", busy2, 1'b1);
        for (int i = 0; i < 8; i++) begin
            mosi2 = opt_bits[i][0];
            sck2  = 1'b1;
            tick(2);
            sck2  = 1'b0;
            tick(2);
        end
        tick(4);
        check_eq("t6_word", {valid2, data2}, {1'b1, 8'h05});
        cs2 = 1'b0; tick(6);
        check_eq("t6_flags", {busy2, overrun2, frame_err2}, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
